// File: rtl/mul_serial_pkg.sv
// Shared types and width helpers for the bit-serial multiplier sequencing controller.
package mul_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_serial_state_t;

  // Accumulator and product width for a given operand width.
  function automatic int unsigned acc_width(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/mul_serial_ctrl_if.sv
// Handshake and datapath bundle between feeder, controller, multiplier datapath and consumer.
interface mul_serial_ctrl_if
  import mul_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 16
);

  logic                         i_valid;
  logic                         i_ready;
  logic [WIDTH-1:0]             i_data0;
  logic [WIDTH-1:0]             i_data1;
  logic                         o_mul_clr;
  logic [WIDTH-1:0]             o_mul_data0;
  logic [WIDTH-1:0]             o_mul_data1;
  logic [acc_width(WIDTH)-1:0]  i_mul_pp;
  logic                         o_valid;
  logic                         i_out_ready;
  logic [acc_width(WIDTH)-1:0]  o_data;
  logic                         o_busy;

  modport master (
    input  i_valid, i_data0, i_data1, i_mul_pp, i_out_ready,
    output i_ready, o_mul_clr, o_mul_data0, o_mul_data1, o_valid, o_data, o_busy
  );

  modport slave (
    output i_valid, i_data0, i_data1, i_mul_pp, i_out_ready,
    input  i_ready, o_mul_clr, o_mul_data0, o_mul_data1, o_valid, o_data, o_busy
  );

endinterface

// File: rtl/mul_serial_acc.sv
// Signed shift-add accumulator; the sign-bit partial product is subtracted, and the
// finished sum is captured into a separate product register.
module mul_serial_acc
  import mul_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 last,
  input  logic [DEPTH-1:0]     shamt,
  input  logic [2*WIDTH-1:0]   pp,
  output logic [2*WIDTH-1:0]   acc
);

  localparam int unsigned AW = acc_width(WIDTH);

  logic [AW-1:0] sum_q, sum_d;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] term;

  // Left shift is identical for signed and unsigned two's-complement patterns.
  assign term = pp << shamt;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = last ? (sum_q - term) : (sum_q + term);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      acc_q <= '0;
    end else begin
      sum_q <= sum_d;
      if (en && last) begin
        acc_q <= sum_d;
      end
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mul_serial_ctrl.sv
// Sequencing controller for the bit-serial border multiplier: operand handshake, datapath
// clear, shift-add accumulation and product handshake.
module mul_serial_ctrl
  import mul_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  mul_serial_ctrl_if.master bus
);

  mul_serial_state_t  state_q, state_d;
  logic [DEPTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   data0_q, data1_q;
  logic               accept;
  logic               in_run;
  logic               last;
  logic [2*WIDTH-1:0] acc;

  assign bus.i_ready = (state_q == IDLE) | ((state_q == DONE) & bus.i_out_ready);
  assign accept      = bus.i_valid & bus.i_ready;
  assign in_run      = (state_q == RUN);
  assign last        = in_run & (cnt_q == DEPTH'(WIDTH - 1));

  // Clear stays high outside RUN so the datapath counter starts at 0 with ours.
  assign bus.o_mul_clr   = ~in_run;
  assign bus.o_busy      = in_run;
  assign bus.o_valid     = (state_q == DONE);
  assign bus.o_mul_data0 = data0_q;
  assign bus.o_mul_data1 = data1_q;
  assign bus.o_data      = acc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Wraps to 0 exactly as DONE is entered.
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_out_ready) begin
          state_d = bus.i_valid ? RUN : IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        data0_q <= bus.i_data0;
        data1_q <= bus.i_data1;
      end
    end
  end

  mul_serial_acc #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (in_run),
    .last (last),
    .shamt(cnt_q),
    .pp   (bus.i_mul_pp),
    .acc  (acc)
  );

endmodule
